pool_window_buffer: RTL
=======================

Name: pool_window_buffer

Overview:
- Streaming window-assembly stage directly upstream of the max-pooling unit.
- Accepts conv/activation output pixels one per cycle in raster order (row-major, top-left first).
- Buffers one feature-map row and emits each non-overlapping 2x2, stride-2 window as 4 parallel values with a valid strobe.
- Drives the max-pooling unit's `ifm_input[3:0]` bus, whose pool size is 4.

Parameters:
- DATA_WIDTH, 20, bit width of each pixel in and out.
- FMAP_WIDTH, 28, pixels per input row; must be >= 2.
- FMAP_HEIGHT, 28, rows per input frame; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a valid pixel this cycle.
- in_data  input  DATA_WIDTH  pixel value, raster order.
- out_valid  output  1  one-cycle strobe; out_window holds a complete window.
- out_window  output  DATA_WIDTH x 4 (unpacked [3:0])  window pixels:
  - [0] top-left
  - [1] top-right
  - [2] bottom-left
  - [3] bottom-right
- frame_done  output  1  one-cycle pulse with the last window of a frame.
- col_idx  output  $clog2(FMAP_WIDTH)  column of the next expected pixel (debug/verification).
- row_idx  output  $clog2(FMAP_HEIGHT)  row of the next expected pixel.

Behaviour:
- Reset (rst_n=0, asynchronous) clears the following:
  - out_valid=0, out_window all 0, frame_done=0, col_idx=0, row_idx=0.
  - The line buffer and the held-left pixel register. Clearing these is not required functionally, but they must be cleared for deterministic sim.
- Counters:
  - Advance only on in_valid=1.
  - col_idx increments 0..FMAP_WIDTH-1, then wraps to 0 and row_idx increments.
  - row_idx wraps 0 after FMAP_HEIGHT-1, so the next frame starts with no idle cycle.
  - in_valid=0 cycles hold all state; gaps of any length are legal.
- Even row (row_idx[0]=0): each valid pixel is written to line_buf[col_idx]. No output.
- Odd row, even column: the pixel is captured in the left register. No output.
- Odd row, odd column (window complete):
  - Next cycle: out_window = {line_buf[c-1], line_buf[c], left_reg, in_data}, in the order [0],[1],[2],[3].
  - out_valid=1 for exactly one cycle.
  - Latency is 1 clock from the completing input pixel.
- out_window holds its last value when out_valid=0. It is not cleared between windows.
- Odd FMAP_WIDTH: the last column of each row is consumed (counters advance) but is never part of a window, and is not written as a left pixel for a window.
- Odd FMAP_HEIGHT: the last row is consumed and discarded. The line buffer is written but never read. The next frame starts clean.
- Windows per frame = floor(W/2)*floor(H/2). Each output window is emitted exactly once.
- frame_done asserts together with out_valid for the window at row 2*floor(H/2)-1, column 2*floor(W/2)-1.
- Back-to-back: a continuous in_valid stream yields out_valid on every other cycle during odd rows. There is no backpressure; the downstream stage must accept every window.
- Values pass through unmodified: no arithmetic, sign-agnostic.
- Reset mid-frame discards any partial window and restarts at row 0, col 0. No out_valid is produced from pre-reset data.
- Line-buffer read/write hazard: an even-row write to line_buf[c] never coincides with an odd-row read. The single-port-per-direction register array needs no bypass.

Test Plan:
- 4x4 frame, pixels 1..16 raster, in_valid continuous:
  - Windows {1,2,5,6}, {3,4,7,8}, {9,10,13,14}, {11,12,15,16}.
  - out_valid 1 cycle after pixels 6, 8, 14, 16.
  - frame_done only with {11,12,15,16}.
- Same 4x4 frame with in_valid toggled randomly (~50% duty): identical window sequence and values. out_valid is never asserted while counters stall.
- 5x5 frame (W=H=5), pixels 1..25:
  - Exactly 4 windows: {1,2,6,7}, {3,4,8,9}, {11,12,16,17}, {13,14,18,19}.
  - Column 4 and row 4 are dropped.
  - frame_done with {13,14,18,19}.
  - The following frame starts at row 0, col 0.
- Two back-to-back 4x4 frames (1..16, then 101..116): the second frame's first window is {101,102,105,106}, with no cross-frame mixing.
- rst_n pulsed low after pixel 6's window but before pixel 7 of a 4x4 frame:
  - Outputs go to 0 immediately (async).
  - After release, a fresh 1..16 frame produces the normal four windows.
- Max values 0xFFFFF and min value 0 in mixed positions (DATA_WIDTH=20): windows pass bits through exactly.

Source files
------------

// File: rtl/pool_window_buffer_if.sv
// rtl/pool_window_buffer_if.sv - pixel-in / window-out bus of the pooling window buffer
interface pool_window_buffer_if #(
    parameter int DATA_WIDTH = 20
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_window [3:0];
    logic                  frame_done;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_window, frame_done
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_window, frame_done
    );
endinterface

// File: rtl/pool_window_buffer.sv
// rtl/pool_window_buffer.sv - assembles raster pixels into 2x2 stride-2 windows for max pooling
module pool_window_buffer #(
    parameter int DATA_WIDTH  = 20,
    parameter int FMAP_WIDTH  = 28,
    parameter int FMAP_HEIGHT = 28,
    localparam int CW = $clog2(FMAP_WIDTH),
    localparam int RW = $clog2(FMAP_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pool_window_buffer_if.slave  bus,
    output logic [CW-1:0]        col_idx,
    output logic [RW-1:0]        row_idx
);
    localparam logic [CW-1:0] LAST_COL = CW'(FMAP_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(FMAP_HEIGHT - 1);
    localparam logic [CW-1:0] FD_COL   = CW'(2 * (FMAP_WIDTH / 2) - 1);
    localparam logic [RW-1:0] FD_ROW   = RW'(2 * (FMAP_HEIGHT / 2) - 1);
    localparam bit            ODD_W    = (FMAP_WIDTH % 2) != 0;

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] line_buf_q [0:FMAP_WIDTH-1];
    logic [DATA_WIDTH-1:0] line_buf_d [0:FMAP_WIDTH-1];
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_WIDTH-1:0] out_window_q [3:0];
    logic [DATA_WIDTH-1:0] out_window_d [3:0];
    logic                  col_paired;

    // An unpaired trailing column on odd-width maps never becomes a left pixel.
    assign col_paired = ODD_W ? (col_q != LAST_COL) : 1'b1;

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        line_buf_d   = line_buf_q;
        left_d       = left_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        out_window_d = out_window_q;
        if (bus.in_valid) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!row_q[0]) begin
                line_buf_d[col_q] = bus.in_data;
            end else if (!col_q[0]) begin
                if (col_paired) begin
                    left_d = bus.in_data;
                end
            end else begin
                out_valid_d     = 1'b1;
                out_window_d[0] = line_buf_q[col_q - 1'b1];
                out_window_d[1] = line_buf_q[col_q];
                out_window_d[2] = left_q;
                out_window_d[3] = bus.in_data;
                frame_done_d    = (row_q == FD_ROW) && (col_q == FD_COL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            left_q       <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < FMAP_WIDTH; i++) begin
                line_buf_q[i] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                out_window_q[k] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            left_q       <= left_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            line_buf_q   <= line_buf_d;
            out_window_q <= out_window_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.out_window = out_window_q;
    assign col_idx        = col_q;
    assign row_idx        = row_q;
endmodule
